// File: rtl/prog_timer.sv
// Programmable countdown timer with prescaler, one-shot/auto-reload modes, level pause,
// done level, expire pulse and a square-wave output derived from the count.
module prog_timer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned DEFAULT_LOAD = 99999999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             expire,
    output logic             wave
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PscLast = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;
    logic             tick;

    // A cycle with stop low in PAUSE counts as a running cycle, so stop freezes
    // the count for exactly as many cycles as it is held.
    assign tick = (state_q == StRun || state_q == StPause) && !stop && (psc_q == PscLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        psc_d    = psc_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (start) begin
            cnt_d    = (load_val == '0) ? One : load_val;
            reload_d = cnt_d;
            mode_d   = mode;
            psc_d    = '0;
            state_d  = StRun;
        end else begin
            unique case (state_q)
                StIdle, StDone: psc_d = '0;
                StRun, StPause: begin
                    if (stop) begin
                        state_d = StPause;
                    end else begin
                        state_d = StRun;
                        if (tick) begin
                            psc_d = '0;
                            if (cnt_q > One) begin
                                cnt_d = cnt_q - One;
                            end else begin
                                expire_d = 1'b1;
                                if (mode_q) begin
                                    cnt_d = reload_q;
                                end else begin
                                    cnt_d   = '0;
                                    state_d = StDone;
                                end
                            end
                        end else begin
                            psc_d = psc_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            reload_q <= WIDTH'(DEFAULT_LOAD);
            psc_q    <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            psc_q    <= psc_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    assign cnt    = cnt_q;
    assign busy   = (state_q == StRun) || (state_q == StPause);
    assign done   = (state_q == StDone);
    assign expire = expire_q;
    assign wave   = mode_q && busy && (cnt_q > (reload_q >> 1));

endmodule
